// File: rtl/ram_ptr_pkg.sv
// Shared pointer helpers for the circular sample-RAM address controller:
// start value and wrap-aware step for either count direction.
package ram_ptr_pkg;

    typedef enum logic {
        PTR_UP,
        PTR_DOWN
    } ptr_dir_e;

    function automatic int unsigned ptr_start(input int unsigned depth, input ptr_dir_e dir);
        return (dir == PTR_DOWN) ? depth - 1 : 0;
    endfunction

    // Wrap is against DEPTH, not the address width, so non-power-of-two depths stay in range.
    function automatic int unsigned ptr_step(input int unsigned ptr, input int unsigned depth,
                                             input ptr_dir_e dir);
        if (dir == PTR_DOWN)
            return (ptr == 0) ? depth - 1 : ptr - 1;
        else
            return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ram_ptr_wrap.sv
// Single wrapping address pointer; one instance each for the write and read side.
// Steps on the edge after an accepted request; clr returns it to the start value.
module ram_ptr_wrap
    import ram_ptr_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2**ADDR_W,
    parameter bit          DOWN   = 1'b1
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              step,
    output logic [ADDR_W-1:0] ptr
);

    localparam ptr_dir_e          DIR   = DOWN ? PTR_DOWN : PTR_UP;
    localparam logic [ADDR_W-1:0] START = ADDR_W'(ptr_start(DEPTH, DIR));

    logic [ADDR_W-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ADDR_W'(ptr_step(32'(ptr), DEPTH, DIR));
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n)
            ptr <= START;
        else if (clr)
            ptr <= START;
        else if (step)
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/ram_ptr_ctl.sv
// Circular-buffer pointer controller: write/read pointers, occupancy, flags, sticky errors.
// Optional almost_full output when RAM_PTR_AF_EN is defined.
module ram_ptr_ctl
    import ram_ptr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DEPTH    = 2**ADDR_W,
    parameter bit          DOWN     = 1'b1
`ifdef RAM_PTR_AF_EN
    ,
    parameter int unsigned AF_LEVEL = DEPTH - 4
`endif
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wr_ram,
    input  logic              rd_ram,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              wr_err,
    output logic              rd_err
`ifdef RAM_PTR_AF_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic            wr_acc;
    logic            rd_acc;
    logic [ADDR_W:0] count_nxt;

    always_comb begin
        wr_acc = wr_ram & ~full;
        rd_acc = rd_ram & ~empty;
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    ram_ptr_wrap #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DOWN   (DOWN)
    ) u_wr_ptr (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .clr     (clr),
        .step    (wr_acc),
        .ptr     (wr_addr)
    );

    ram_ptr_wrap #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DOWN   (DOWN)
    ) u_rd_ptr (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .clr     (clr),
        .step    (rd_acc),
        .ptr     (rd_addr)
    );

    // Flags are registered from next-count so they move on the same edge as count.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
            if (wr_ram && full)
                wr_err <= 1'b1;
            if (rd_ram && empty)
                rd_err <= 1'b1;
        end
    end

`ifdef RAM_PTR_AF_EN
    localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n)
            almost_full <= 1'b0;
        else if (clr)
            almost_full <= 1'b0;
        else
            almost_full <= (count_nxt >= AF_C);
    end
`endif

endmodule
